// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-setting controller.
// Optional feature macro used by time_set_ctrl: AUTO_REPEAT_EN.
package time_set_pkg;

  localparam int FIELD_W = 6;

  typedef logic [FIELD_W-1:0] field_t;

  localparam field_t SEC_MAX  = 6'd59;
  localparam field_t MIN_MAX  = 6'd59;
  localparam field_t HOUR_MAX = 6'd23;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_SEC  = 3'd3,
    ST_COMMIT   = 3'd4
  } state_e;

  // One wrapping step up or down within 0..max.
  function automatic field_t step_field(input field_t v, input field_t max, input logic up);
    if (up) return (v == max)  ? '0  : v + 6'd1;
    else    return (v == '0)   ? max : v - 6'd1;
  endfunction

  // Counter-chain values outside the legal range start editing from zero.
  function automatic field_t clamp_field(input field_t v, input field_t max);
    return (v > max) ? '0 : v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchronizer, stability counter and
// rising-edge press detect on the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count cycles the synchronized level disagrees with the stable level;
  // flip the stable level once the disagreement has lasted long enough.
  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    cnt_d        = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
    end
  end

  assign level = stable_q;
  assign press = stable_q & ~stable_dly_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-setting controller for the sec/min/hour counter chain.
// Walks RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> COMMIT on mode presses and
// issues a one-cycle load of the edited time on commit.
// Optional: define AUTO_REPEAT_EN for held-button auto-repeat stepping.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               btn_mode,
  input  logic               btn_inc,
  input  logic               btn_dec,
  input  logic [FIELD_W-1:0] count_sec,
  input  logic [FIELD_W-1:0] count_min,
  input  logic [FIELD_W-1:0] count_hour,
  output logic               enable,
  output logic               setting1,
  output logic               setting2,
  output logic               setting3,
  output logic               load,
  output logic [FIELD_W-1:0] data_sec,
  output logic [FIELD_W-1:0] data_min,
  output logic [FIELD_W-1:0] data_hour,
  output logic [2:0]         edit_state
);

  logic mode_press, inc_press, dec_press;
  logic mode_lvl, inc_lvl, dec_lvl;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clock(clock), .reset_n(reset_n), .btn_raw(btn_mode), .level(mode_lvl), .press(mode_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clock(clock), .reset_n(reset_n), .btn_raw(btn_inc), .level(inc_lvl), .press(inc_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clock(clock), .reset_n(reset_n), .btn_raw(btn_dec), .level(dec_lvl), .press(dec_press)
  );

  state_e state_q, state_d;
  field_t hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic   enable_q, enable_d;
  logic   set1_q, set1_d, set2_q, set2_d, set3_q, set3_d;
  logic   load_q, load_d;
  logic   step_en, step_up;
  logic   in_set;

  assign in_set = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN) || (state_q == ST_SET_SEC);

`ifdef AUTO_REPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_active;
  logic             unused_lvl;

  // Mode level is never consulted; only its press edge drives the FSM.
  assign unused_lvl = mode_lvl;

  // Exactly one of inc/dec held in an edit state with no mode press pending.
  assign rep_active = in_set && (inc_lvl ^ dec_lvl) && !mode_press;

  // Step source: a fresh single press, or a repeat tick while held.
  always_comb begin
    step_en   = 1'b0;
    step_up   = 1'b0;
    rep_cnt_d = rep_cnt_q;
    if (inc_press ^ dec_press) begin
      step_en = 1'b1;
      step_up = inc_press;
    end
    if (!rep_active || inc_press || dec_press) begin
      rep_cnt_d = '0;
    end else if (rep_cnt_q == REP_W'(REPEAT_CYCLES - 1)) begin
      rep_cnt_d = '0;
      step_en   = 1'b1;
      step_up   = inc_lvl;
    end else begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  // Repeat interval counter.
  always_ff @(posedge clock) begin
    if (!reset_n) rep_cnt_q <= '0;
    else          rep_cnt_q <= rep_cnt_d;
  end
`else
  logic unused_cfg;

  // Levels and repeat interval have no consumer when auto-repeat is off.
  assign unused_cfg = mode_lvl ^ inc_lvl ^ dec_lvl ^ (REPEAT_CYCLES > 0);

  // Step source: a single press of exactly one of inc/dec.
  always_comb begin
    step_en = 1'b0;
    step_up = 1'b0;
    if (inc_press ^ dec_press) begin
      step_en = 1'b1;
      step_up = inc_press;
    end
  end
`endif

  // Next state, edit registers and registered outputs derived from next state.
  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    unique case (state_q)
      ST_RUN: begin
        if (mode_press) begin
          state_d = ST_SET_HOUR;
          hour_d  = clamp_field(count_hour, HOUR_MAX);
          min_d   = clamp_field(count_min, MIN_MAX);
          sec_d   = clamp_field(count_sec, SEC_MAX);
        end
      end
      ST_SET_HOUR: begin
        if (mode_press)   state_d = ST_SET_MIN;
        else if (step_en) hour_d  = step_field(hour_q, HOUR_MAX, step_up);
      end
      ST_SET_MIN: begin
        if (mode_press)   state_d = ST_SET_SEC;
        else if (step_en) min_d   = step_field(min_q, MIN_MAX, step_up);
      end
      ST_SET_SEC: begin
        if (mode_press)   state_d = ST_COMMIT;
        else if (step_en) sec_d   = step_field(sec_q, SEC_MAX, step_up);
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
    enable_d = (state_d == ST_RUN);
    set3_d   = (state_d == ST_SET_HOUR);
    set2_d   = (state_d == ST_SET_MIN);
    set1_d   = (state_d == ST_SET_SEC);
    load_d   = (state_d == ST_COMMIT);
  end

  // FSM state, edit registers and outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      hour_q   <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      enable_q <= 1'b1;
      set1_q   <= 1'b0;
      set2_q   <= 1'b0;
      set3_q   <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hour_q   <= hour_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      enable_q <= enable_d;
      set1_q   <= set1_d;
      set2_q   <= set2_d;
      set3_q   <= set3_d;
      load_q   <= load_d;
    end
  end

  assign enable     = enable_q;
  assign setting1   = set1_q;
  assign setting2   = set2_q;
  assign setting3   = set3_q;
  assign load       = load_q;
  assign data_hour  = hour_q;
  assign data_min   = min_q;
  assign data_sec   = sec_q;
  assign edit_state = state_q;

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Button-driven time-setting controller: the write side of the clock counter chain's load/data interface. Debounces three raw push-buttons and walks through hour, minute and second editing. On commit it issues a single-cycle load with the edited values. It sits between the board buttons and the seconds/minutes/hours counter chain, driving its enable, setting, load and data inputs and reading back its count outputs.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required to accept a button level change (≥2).
- REPEAT_CYCLES, 64: auto-repeat interval in clocks; used only with AUTO_REPEAT_EN.
- clock  in  1  single system clock; all logic on its rising edge.
- reset_n  in  1  synchronous reset, active-low.
- btn_mode  in  1  raw, asynchronous mode button, active-high.
- btn_inc  in  1  raw increment button.
- btn_dec  in  1  raw decrement button.
- count_sec, count_min, count_hour  in  6 each  current time from the counter chain.
- enable  out  1  counter-chain run enable; 1 only in RUN.
- setting1, setting2, setting3  out  1 each  field-being-edited flags: seconds, minutes, hours.
- load  out  1  single-cycle commit strobe.
- data_sec, data_min, data_hour  out  6 each  edit registers; meaningful when load=1.
- edit_state  out  3  current FSM state encoding.

## Operation
- Each button path:
  - 2-flop synchronizer, then debounce counter.
  - The counter clears whenever the synchronized level equals the stable level.
  - Stable level toggles when the synchronized level has differed for DEBOUNCE_CYCLES consecutive cycles.
  - press = stable & ~stable_d.
  - Glitches shorter than DEBOUNCE_CYCLES produce no press.
- FSM states and transitions: RUN → SET_HOUR → SET_MIN → SET_SEC → COMMIT → RUN.
  - Every transition except COMMIT→RUN is taken on a mode press.
  - COMMIT lasts exactly one cycle.
- RUN→SET_HOUR captures count_* into the edit registers. Any captured field above its maximum is replaced by 0.
- Editing rules (only the current field changes):
  - In a SET_* state, an inc press adds 1 to that field, wrapping 59→0 for sec/min and 23→0 for hour.
  - A dec press subtracts 1, wrapping 0→59 and 0→23.
- Outputs by state:
  - enable=1 only in RUN.
  - setting3=1 only in SET_HOUR, setting2=1 only in SET_MIN, setting1=1 only in SET_SEC.
  - load=1 only in COMMIT, with data_* equal to the edit registers.
- Simultaneous events:
  - inc and dec pressed in the same cycle: both ignored.
  - mode pressed with inc or dec: the transition is taken and inc/dec is discarded.
  - inc/dec presses in RUN or COMMIT: ignored.
- Reset values: state RUN, enable=1, setting1..3=0, load=0, data_*=0, stable levels 0, all counters 0.
- Reset mid-edit: returns to RUN with no load pulse. The counter chain keeps its own time, because it free-runs again once enable=1.

## Timing
- Raw edge before clock edge t, held stable → stable level updates at edge t+2+DEBOUNCE_CYCLES.
- The press pulse is high in the following cycle.
- The FSM and edit registers update at edge t+3+DEBOUNCE_CYCLES.
- The capture on entry to SET_HOUR uses the count_* values sampled at that same edge.
- COMMIT: load high for exactly one cycle. enable is 0 during that cycle and 1 from the next cycle.
- A release is debounced identically but generates no action.

## Configuration
- AUTO_REPEAT_EN defined:
  - While the debounced inc (or dec) stays high in a SET_* state, an extra step occurs every REPEAT_CYCLES clocks after the initial press step.
  - The repeat counter clears on release, on a state change, or if both buttons are held.
- AUTO_REPEAT_EN undefined: exactly one step per press. REPEAT_CYCLES is unused and no repeat counter is synthesized.

## Structure
- Package time_set_pkg holds:
  - state encoding: RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3, COMMIT=4.
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - field width 6.
- Sub-module btn_debounce (synchronizer, debounce counter and press edge), instantiated three times with DEBOUNCE_CYCLES passed through.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=8.
- Reset then idle → enable=1, load=0, setting*=0, data_*=0, edit_state=0.
- Counts 10:20:30, mode press → edit_state=1 at edge t+7, setting3=1, enable=0, data_hour=10.
- Full pass: hour 23 + inc → 0; mode; min 0 + dec → 59; mode; sec 30 + inc ×2 → 32; mode → one-cycle load with data 0:59:32, then enable=1.
- Glitch of 3 cycles on btn_inc in SET_MIN → no change. Simultaneous inc and dec press → no change.
- reset_n low during SET_SEC → next cycle RUN, load never asserted.
- With AUTO_REPEAT_EN: hold inc 40 cycles after press in SET_SEC from 0 → value 1 + floor(elapsed/8) steps, wrapping at 59. Without it → value 1.
